serial_adder_borrow_subtractor: RTL and testbench

//  Bit-serial counterpart of the team's 4-bit ripple-carry add/sub unit.
//  One full-adder cell is reused over WIDTH clock cycles, LSB first, with a registered carry.

---
 rtl/serial_adder_borrow_subtractor_pkg.sv | 20 ++
 rtl/serial_adder_borrow_subtractor_full_adder.sv | 20 ++
 rtl/serial_adder_borrow_subtractor.sv | 109 ++++++++++
 tb/tb_serial_adder_borrow_subtractor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_borrow_subtractor_pkg.sv
// ============================================================================
// serial_adder_borrow_subtractor_pkg : shared FSM encodings and mode values
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_borrow_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_adder_borrow_subtractor_full_adder.sv
// ============================================================================
// full_adder_m : single-bit full adder cell reused by the bit-serial unit
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_m (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder_borrow_subtractor.sv
// ============================================================================
// serial_adder_borrow_subtractor : bit-serial add/sub, one full adder, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder_borrow_subtractor
  import serial_adder_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   result_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               carry_borrow_q;
  logic               fa_sum;
  logic               fa_cout;

  full_adder_m u_full_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state          <= ST_IDLE;
      a_sh           <= '0;
      b_sh           <= '0;
      result_q       <= '0;
      cnt            <= '0;
      carry          <= 1'b0;
      carry_borrow_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{mode != MODE_ADD}};
            carry    <= (mode == MODE_SUB);
            cnt      <= '0;
            result_q <= '0;
          end
        end
        ST_SHIFT: begin
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          carry    <= fa_cout;
          cnt      <= cnt + CNT_W'(1);
        end
        ST_DONE: begin
          carry_borrow_q <= carry;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  // The final carry is visible during the done cycle and held in the register afterwards.
  assign carry_borrow = (state == ST_DONE) ? carry : carry_borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_borrow_subtractor.sv
// ============================================================================
// tb_serial_adder_borrow_subtractor : directed and exhaustive checks, WIDTH=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_borrow_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_p = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_borrow;

  int checks = 0;
  int failures = 0;

  serial_adder_borrow_subtractor #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .start        (start),
    .mode         (mode),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .carry_borrow (carry_borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues start and returns at the negedge of the done cycle.
  task automatic run_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic mm, output int cyc, output int done_cnt);
    cyc = 0;
    done_cnt = 0;
    a = aa; b = bb; mode = mm; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        cyc = c;
        break;
      end
    end
  endtask

  int cyc;
  int dn;
  int pulses;
  logic [WIDTH:0] expv;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cb", carry_borrow, 0);
    reset_p = 1'b0;
    @(negedge clk);

    // 1: 5+3
    run_op(4'd5, 4'd3, 1'b0, cyc, dn);
    check("t1_latency", cyc, 5);
    check("t1_result", result, 4'h8);
    check("t1_cb", carry_borrow, 0);
    @(negedge clk);
    check("t1_busy_idle", busy, 0);
    check("t1_hold", result, 4'h8);

    // 2: F+1 wraps with carry out
    run_op(4'hF, 4'h1, 1'b0, cyc, dn);
    check("t2_result", result, 4'h0);
    check("t2_cb", carry_borrow, 1);
    @(negedge clk);
    check("t2_cb_hold", carry_borrow, 1);

    // 3: 7-3 then 3-7
    run_op(4'd7, 4'd3, 1'b1, cyc, dn);
    check("t3a_result", result, 4'h4);
    check("t3a_cb", carry_borrow, 1);
    @(negedge clk);
    run_op(4'd3, 4'd7, 1'b1, cyc, dn);
    check("t3b_result", result, 4'hC);
    check("t3b_cb", carry_borrow, 0);
    @(negedge clk);

    // 4: start during SHIFT is ignored
    a = 4'd2; b = 4'd9; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    check("t4_busy", busy, 1);
    start = 1'b0;
    @(negedge clk);
    a = 4'hE; b = 4'hE; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) begin
        pulses++;
        check("t4_result", result, 4'hB);
        check("t4_cb", carry_borrow, 0);
      end
      @(negedge clk);
    end
    check("t4_pulses", pulses, 1);
    check("t4_idle", busy, 0);

    // 5: reset at SHIFT cycle 2 aborts
    a = 4'd6; b = 4'd6; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_result", result, 0);
    check("t5_cb", carry_borrow, 0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("t5_no_done", pulses, 0);
    run_op(4'd6, 4'd6, 1'b0, cyc, dn);
    check("t5_latency", cyc, 5);
    check("t5_result2", result, 4'hC);
    @(negedge clk);

    // Reset and start together: reset wins
    reset_p = 1'b1; start = 1'b1; a = 4'd1; b = 4'd1; mode = 1'b0;
    @(negedge clk);
    reset_p = 1'b0; start = 1'b0;
    check("rs_busy", busy, 0);
    check("rs_result", result, 0);
    @(negedge clk);
    check("rs_busy2", busy, 0);

    // 6: exhaustive back-to-back
    for (int m = 0; m < 2; m++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if (m == 0) expv = {1'b0, 4'(ia)} + {1'b0, 4'(ib)};
          else        expv = {1'b0, 4'(ia)} + {1'b0, ~4'(ib)} + 5'd1;
          run_op(4'(ia), 4'(ib), 1'(m), cyc, dn);
          check($sformatf("ex_m%0d_a%0h_b%0h", m, ia, ib), {27'd0, carry_borrow, result},
                {27'd0, expv});
          @(negedge clk);
          check($sformatf("ex_hold_m%0d_a%0h_b%0h", m, ia, ib), {27'd0, carry_borrow, result},
                {27'd0, expv});
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
